// File: rtl/writeback_queue.sv
// Writeback queue sitting in front of the register-file write port.
// Buffers memory-stage results in a small FIFO, applies load width/sign
// extension on the way out, and publishes a busy mask of destination
// registers that still have a write pending so decode can stall on RAW.
module writeback_queue #(
   parameter  int DEPTH = 4,
   localparam int PTR_W = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [4:0]       in_rd,
   input  logic [5:0]       in_opcode,
   input  logic [63:0]      in_data,
   input  logic             wb_stall,
   output logic             reg_write,
   output logic [4:0]       write_rd,
   output logic [63:0]      write_data,
   output logic [31:0]      busy_mask,
   output logic [PTR_W:0]   count
);

   localparam logic [5:0] OP_LWZ = 6'd32;
   localparam logic [5:0] OP_LBZ = 6'd34;
   localparam logic [5:0] OP_LHZ = 6'd40;
   localparam logic [5:0] OP_LHA = 6'd42;

   localparam logic [PTR_W:0] FULL_COUNT = (PTR_W+1)'(DEPTH);

   logic [4:0]       r_rd   [DEPTH];
   logic [5:0]       r_op   [DEPTH];
   logic [63:0]      r_data [DEPTH];
   logic [DEPTH-1:0] r_vld;
   logic [PTR_W-1:0] r_head;
   logic [PTR_W-1:0] r_tail;
   logic [PTR_W:0]   r_count;
   logic             r_reg_write;
   logic [4:0]       r_write_rd;
   logic [63:0]      r_write_data;

   logic             w_push;
   logic             w_pop;
   logic [31:0]      w_busy;
   logic [63:0]      w_ext_data;

   // Loads narrower than a doubleword are extended here; everything else
   // (ld, ALU results) passes through untouched.
   function automatic logic [63:0] extend(input logic [5:0] op, input logic [63:0] d);
      logic [63:0] res;
      case (op)
         OP_LBZ:  res = {56'd0, d[7:0]};
         OP_LHZ:  res = {48'd0, d[15:0]};
         OP_LHA:  res = {{48{d[15]}}, d[15:0]};
         OP_LWZ:  res = {32'd0, d[31:0]};
         default: res = d;
      endcase
      return res;
   endfunction

   // Handshake qualifiers; in_ready depends on occupancy only, so a full
   // queue never accepts even if it pops on the same edge.
   always_comb begin
      in_ready   = (r_count < FULL_COUNT);
      w_push     = in_valid && in_ready;
      w_pop      = (r_count != '0) && !wb_stall;
      w_ext_data = extend(r_op[r_head], r_data[r_head]);
   end

   // Entry payload storage; needs no reset because r_vld qualifies it.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_rd[r_tail]   <= in_rd;
         r_op[r_tail]   <= in_opcode;
         r_data[r_tail] <= in_data;
      end
   end

   // Pointer, occupancy and per-entry valid bookkeeping.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
         r_vld   <= '0;
      end else begin
         if (w_push) begin
            r_tail        <= r_tail + 1'b1;
            r_vld[r_tail] <= 1'b1;
         end
         if (w_pop) begin
            r_head        <= r_head + 1'b1;
            r_vld[r_head] <= 1'b0;
         end
         if (w_push && !w_pop)
            r_count <= r_count + 1'b1;
         else if (w_pop && !w_push)
            r_count <= r_count - 1'b1;
      end
   end

   // Output register: one write pulse per popped entry; rd/data hold
   // their last values between pulses.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_reg_write  <= 1'b0;
         r_write_rd   <= '0;
         r_write_data <= '0;
      end else begin
         r_reg_write <= w_pop;
         if (w_pop) begin
            r_write_rd   <= r_rd[r_head];
            r_write_data <= w_ext_data;
         end
      end
   end

   // Busy mask covers every queued entry plus the write currently on the
   // port, so a register stays busy until its last pending write retires.
   always_comb begin
      w_busy = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (r_vld[i])
            w_busy = w_busy | (32'd1 << r_rd[i]);
      end
      if (r_reg_write)
         w_busy = w_busy | (32'd1 << r_write_rd);
   end

   assign busy_mask  = w_busy;
   assign count      = r_count;
   assign reg_write  = r_reg_write;
   assign write_rd   = r_write_rd;
   assign write_data = r_write_data;

endmodule

// File: tb/tb_writeback_queue.sv
module tb_writeback_queue;

   localparam int DEPTH = 4;
   localparam int PTR_W = $clog2(DEPTH);

   logic             clk;
   logic             rst_n;
   logic             in_valid;
   logic             in_ready;
   logic [4:0]       in_rd;
   logic [5:0]       in_opcode;
   logic [63:0]      in_data;
   logic             wb_stall;
   logic             reg_write;
   logic [4:0]       write_rd;
   logic [63:0]      write_data;
   logic [31:0]      busy_mask;
   logic [PTR_W:0]   count;

   int n_checks = 0;
   int n_errors = 0;

   writeback_queue #(.DEPTH(DEPTH)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_rd      (in_rd),
      .in_opcode  (in_opcode),
      .in_data    (in_data),
      .wb_stall   (wb_stall),
      .reg_write  (reg_write),
      .write_rd   (write_rd),
      .write_data (write_data),
      .busy_mask  (busy_mask),
      .count      (count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [4:0]  rd;
      logic [5:0]  op;
      logic [63:0] data;
      logic [63:0] exp_data;
   } vec_t;

   vec_t vecs [7];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      vecs[0] = '{5'd3,  6'd34, 64'h1234_5678_9ABC_DEF0, 64'h0000_0000_0000_00F0};
      vecs[1] = '{5'd4,  6'd40, 64'hFFFF_FFFF_FFFF_8001, 64'h0000_0000_0000_8001};
      vecs[2] = '{5'd5,  6'd42, 64'hFFFF_FFFF_FFFF_8001, 64'hFFFF_FFFF_FFFF_8001};
      vecs[3] = '{5'd6,  6'd32, 64'hFFFF_FFFF_FFFF_8001, 64'h0000_0000_FFFF_8001};
      vecs[4] = '{5'd0,  6'd58, 64'hFFFF_FFFF_FFFF_8001, 64'hFFFF_FFFF_FFFF_8001};
      vecs[5] = '{5'd31, 6'd14, 64'hFFFF_FFFF_FFFF_8001, 64'hFFFF_FFFF_FFFF_8001};
      vecs[6] = '{5'd9,  6'd42, 64'h0000_0000_0000_7FFF, 64'h0000_0000_0000_7FFF};

      rst_n = 1'b0; in_valid = 1'b0; in_rd = '0; in_opcode = '0; in_data = '0; wb_stall = 1'b0;
      #3;
      chk("rst_count",      64'(count),      64'd0);
      chk("rst_in_ready",   64'(in_ready),   64'd1);
      chk("rst_reg_write",  64'(reg_write),  64'd0);
      chk("rst_write_rd",   64'(write_rd),   64'd0);
      chk("rst_write_data", write_data,      64'd0);
      chk("rst_busy",       64'(busy_mask),  64'd0);
      tick();
      rst_n = 1'b1;
      tick();

      // Single push per vector: pulse appears two edges after the push.
      for (int i = 0; i < 7; i++) begin
         in_valid = 1'b1; in_rd = vecs[i].rd; in_opcode = vecs[i].op; in_data = vecs[i].data;
         tick();
         in_valid = 1'b0;
         chk($sformatf("v%0d_count_after_push", i), 64'(count), 64'd1);
         chk($sformatf("v%0d_busy_queued", i), 64'(busy_mask), 64'(32'd1 << vecs[i].rd));
         chk($sformatf("v%0d_no_early_write", i), 64'(reg_write), 64'd0);
         tick();
         chk($sformatf("v%0d_reg_write", i), 64'(reg_write), 64'd1);
         chk($sformatf("v%0d_write_rd", i), 64'(write_rd), 64'(vecs[i].rd));
         chk($sformatf("v%0d_write_data", i), write_data, vecs[i].exp_data);
         chk($sformatf("v%0d_busy_pulse", i), 64'(busy_mask), 64'(32'd1 << vecs[i].rd));
         tick();
         chk($sformatf("v%0d_pulse_end", i), 64'(reg_write), 64'd0);
         chk($sformatf("v%0d_busy_clear", i), 64'(busy_mask), 64'd0);
         chk($sformatf("v%0d_data_hold", i), write_data, vecs[i].exp_data);
      end

      // Fill under stall, fifth held, then drain in order.
      wb_stall = 1'b1;
      for (int i = 0; i < 4; i++) begin
         in_valid = 1'b1; in_rd = 5'(10 + i); in_opcode = 6'd58; in_data = 64'(100 + i);
         tick();
      end
      chk("full_count", 64'(count), 64'd4);
      chk("full_in_ready", 64'(in_ready), 64'd0);
      chk("full_busy", 64'(busy_mask), 64'h0000_3C00);
      in_rd = 5'd14; in_data = 64'd104;
      tick();
      chk("held_count", 64'(count), 64'd4);
      chk("held_reg_write", 64'(reg_write), 64'd0);
      wb_stall = 1'b0;
      tick();
      chk("drain0_count", 64'(count), 64'd3);
      chk("drain0_reg_write", 64'(reg_write), 64'd1);
      chk("drain0_rd", 64'(write_rd), 64'd10);
      chk("drain0_in_ready", 64'(in_ready), 64'd1);
      tick();
      in_valid = 1'b0;
      chk("drain1_count", 64'(count), 64'd3);
      chk("drain1_rd", 64'(write_rd), 64'd11);
      chk("drain1_busy", 64'(busy_mask), 64'h0000_7800);
      for (int i = 2; i < 5; i++) begin
         tick();
         chk($sformatf("drain%0d_reg_write", i), 64'(reg_write), 64'd1);
         chk($sformatf("drain%0d_rd", i), 64'(write_rd), 64'(10 + i));
         chk($sformatf("drain%0d_data", i), write_data, 64'(100 + i));
      end
      tick();
      chk("drain_done_reg_write", 64'(reg_write), 64'd0);
      chk("drain_done_count", 64'(count), 64'd0);

      // Duplicate destination keeps its busy bit until the last write.
      wb_stall = 1'b1;
      in_valid = 1'b1; in_rd = 5'd7; in_opcode = 6'd58; in_data = 64'd1;
      tick();
      in_data = 64'd2;
      tick();
      in_valid = 1'b0;
      chk("dup_busy", 64'(busy_mask), 64'h80);
      chk("dup_count", 64'(count), 64'd2);
      wb_stall = 1'b0;
      tick();
      chk("dup_first_data", write_data, 64'd1);
      chk("dup_busy_first", 64'(busy_mask), 64'h80);
      tick();
      chk("dup_second_data", write_data, 64'd2);
      chk("dup_second_we", 64'(reg_write), 64'd1);
      chk("dup_busy_second", 64'(busy_mask), 64'h80);
      tick();
      chk("dup_busy_clear", 64'(busy_mask), 64'd0);

      // Steady stream: one push and one pop per cycle.
      for (int i = 0; i < 8; i++) begin
         in_valid = 1'b1; in_rd = 5'(i + 1); in_opcode = 6'd58; in_data = 64'(200 + i);
         tick();
         chk($sformatf("stream%0d_count", i), 64'(count), 64'd1);
         chk($sformatf("stream%0d_in_ready", i), 64'(in_ready), 64'd1);
         if (i > 0) begin
            chk($sformatf("stream%0d_reg_write", i), 64'(reg_write), 64'd1);
            chk($sformatf("stream%0d_data", i), write_data, 64'(200 + i - 1));
         end
      end
      in_valid = 1'b0;
      tick();
      chk("stream_last_data", write_data, 64'd207);
      chk("stream_last_count", 64'(count), 64'd0);
      tick();
      chk("stream_idle", 64'(reg_write), 64'd0);

      // Async reset mid-cycle discards queued and in-flight entries.
      wb_stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         in_valid = 1'b1; in_rd = 5'(20 + i); in_opcode = 6'd58; in_data = 64'(300 + i);
         tick();
      end
      in_valid = 1'b0;
      chk("pre_rst_count", 64'(count), 64'd3);
      wb_stall = 1'b0;
      tick();
      chk("pre_rst_reg_write", 64'(reg_write), 64'd1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_count", 64'(count), 64'd0);
      chk("arst_busy", 64'(busy_mask), 64'd0);
      chk("arst_reg_write", 64'(reg_write), 64'd0);
      chk("arst_in_ready", 64'(in_ready), 64'd1);
      tick();
      #2;
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk($sformatf("post_rst%0d_reg_write", i), 64'(reg_write), 64'd0);
         chk($sformatf("post_rst%0d_count", i), 64'(count), 64'd0);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/writeback_queue.md
Name: writeback_queue

Overview:
- Writeback stage directly upstream of the register-file write port.
- Accepts load/ALU results from the memory stage over a valid/ready handshake and buffers them in a DEPTH-entry FIFO.
- Applies per-opcode width/sign extension and drives a one-cycle register write pulse per entry.
- Publishes a 32-bit busy mask of destination registers with pending writes, so decode can stall on read-after-write hazards.

Parameters:
DEPTH, 4, FIFO entries; power of two, >= 2
PTR_W, $clog2(DEPTH), FIFO pointer width (derived, not overridden)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  memory stage presents a result
in_ready  output  1  queue can accept this cycle
in_rd  input  5  destination register index
in_opcode  input  6  primary opcode of producing instruction
in_data  input  64  raw data (memory read or ALU result)
wb_stall  input  1  register file cannot take a write this cycle
reg_write  output  1  write strobe to register file (RegWrite)
write_rd  output  5  destination register of current write
write_data  output  64  extended data for current write
busy_mask  output  32  bit i set = write to GPR i pending
count  output  PTR_W+1  occupied FIFO entries

Behaviour:
- Reset (async, rst_n low):
  - FIFO cleared: head = tail = count = 0.
  - reg_write = 0, write_rd = 0, write_data = 0, busy_mask = 0, in_ready = 1.
  - Mid-operation reset discards all queued and in-flight entries; no write pulse is produced for them.
- Push:
  - in_ready = (count < DEPTH); combinational from count only, never from wb_stall.
  - Entry {rd, opcode, data} is written at tail on the rising edge where in_valid && in_ready.
  - in_valid with in_ready low is held off; no drop, no overwrite.
- Pop:
  - On a rising edge where count > 0 && !wb_stall, head is removed and the output register loads it.
  - On that edge: reg_write <= 1, write_rd <= rd, write_data <= extend(opcode, data).
  - On any other edge reg_write <= 0; write_rd and write_data hold their last values.
  - reg_write is therefore a one-cycle pulse per entry.
  - Back-to-back pops give reg_write high on consecutive cycles.
- Latency: push at edge E, pop no earlier than edge E+1, so reg_write is high in the cycle after E+1 (minimum 2 edges). No bypass path from input to output.
- Simultaneous push and pop on one edge are both performed; count is unchanged.
  - When full, in_ready = 0 even if a pop happens that edge (no pass-through).
- Pointers wrap modulo DEPTH. count ranges 0..DEPTH; it never exceeds DEPTH or underflows.
- Extension rule, extend(opcode, data):
  - 34 (lbz): zero-extend data[7:0]
  - 40 (lhz): zero-extend data[15:0]
  - 42 (lha): sign-extend data[15:0]
  - 32 (lwz): zero-extend data[31:0]
  - any other opcode, including 58 (ld) and ALU results: data unchanged
- busy_mask (combinational):
  - OR of one-hot(rd) over all valid FIFO entries, plus one-hot(write_rd) while reg_write = 1.
  - Duplicate rd entries keep the bit set until the last of them has been written.
  - GPR 0 is an ordinary register and is tracked like any other.
- Ordering: strictly in-order writes. A later entry to the same rd is always written after an earlier one.
- wb_stall only freezes popping. Pushing continues while not full.

Test Plan:
- Reset then single push {rd=3, op=34, data=64'h1234_5678_9ABC_DEF0}, wb_stall=0 -> reg_write pulses exactly once 2 edges later, write_rd=3, write_data=64'hF0. busy_mask bit 3 is set from push until the pulse cycle ends, then 0.
- Extension sweep with data=64'hFFFF_FFFF_FFFF_8001:
  - op 40 -> 64'h8001
  - op 42 -> 64'hFFFF_FFFF_FFFF_8001
  - op 32 -> 64'hFFFF_8001
  - op 58 -> 64'hFFFF_FFFF_FFFF_8001
  - op 14 -> data unchanged
- wb_stall=1, push 5 entries back-to-back -> 4 accepted, in_ready=0 and count=4 after the 4th, 5th held. Release stall -> 4 consecutive reg_write pulses in push order. The 5th is accepted the edge after the first pop (count 4->3) and written as the 5th pulse.
- Push rd=7 twice (data 1, then 2) with wb_stall=1 -> busy_mask=32'h80. Release -> writes 1 then 2; bit 7 stays set until the cycle after the second pulse.
- Steady stream: push every cycle with wb_stall=0 -> count settles at 1, in_ready stays 1, one reg_write per cycle with no gaps or drops.
- Fill 3 entries, assert rst_n=0 asynchronously mid-cycle -> count, busy_mask and reg_write go to 0 immediately. No write pulse follows after rst_n deasserts.
